// File: rtl/generic_rs_if.sv
// Dispatch, wakeup and issue bundle for generic_rs.
// The dispatcher/exec side uses master; the station uses slave.
interface generic_rs_if #(
    parameter int W_DATA    = 32,
    parameter int W_TAG     = 6,
    parameter int W_PAYLOAD = 48,
    parameter int N_WAKE    = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [W_PAYLOAD-1:0]     in_payload;
    logic                     in_src1_valid;
    logic [W_TAG-1:0]         in_src1_tag;
    logic [W_DATA-1:0]        in_src1_data;
    logic                     in_src2_valid;
    logic [W_TAG-1:0]         in_src2_tag;
    logic [W_DATA-1:0]        in_src2_data;
    logic [N_WAKE-1:0]        wake_valid;
    logic [N_WAKE*W_TAG-1:0]  wake_tag;
    logic [N_WAKE*W_DATA-1:0] wake_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [W_PAYLOAD-1:0]     out_payload;
    logic [W_DATA-1:0]        out_src1_data;
    logic [W_DATA-1:0]        out_src2_data;

    modport master (
        output in_valid, in_payload,
        output in_src1_valid, in_src1_tag, in_src1_data,
        output in_src2_valid, in_src2_tag, in_src2_data,
        output wake_valid, wake_tag, wake_data, out_ready,
        input  in_ready, out_valid, out_payload,
        input  out_src1_data, out_src2_data
    );

    modport slave (
        input  in_valid, in_payload,
        input  in_src1_valid, in_src1_tag, in_src1_data,
        input  in_src2_valid, in_src2_tag, in_src2_data,
        input  wake_valid, wake_tag, wake_data, out_ready,
        output in_ready, out_valid, out_payload,
        output out_src1_data, out_src2_data
    );
endinterface

// File: rtl/generic_rs.sv
// Generic reservation station: N_LINE entries, N_WAKE wakeup snoops, 1 issue/cycle.
// RS_AGE_ORDER_EN selects oldest-ready issue; otherwise lowest-index ready.
module generic_rs #(
    parameter int N_LINE    = 16,
    parameter int W_DATA    = 32,
    parameter int W_TAG     = 6,
    parameter int W_PAYLOAD = 48,
    parameter int N_WAKE    = 2
) (
    input  logic                    clock,
    input  logic                    rstn,
    input  logic                    flash,
    generic_rs_if.slave             rs,
    output logic [$clog2(N_LINE):0] count
);
    localparam int W_IDX = $clog2(N_LINE);
    localparam int W_CNT = W_IDX + 1;

    logic [N_LINE-1:0]    occ_q, occ_d;
    logic [N_LINE-1:0]    s1v_q, s1v_d, s2v_q, s2v_d;
    logic [W_TAG-1:0]     s1t_q [N_LINE];
    logic [W_TAG-1:0]     s1t_d [N_LINE];
    logic [W_TAG-1:0]     s2t_q [N_LINE];
    logic [W_TAG-1:0]     s2t_d [N_LINE];
    logic [W_DATA-1:0]    s1d_q [N_LINE];
    logic [W_DATA-1:0]    s1d_d [N_LINE];
    logic [W_DATA-1:0]    s2d_q [N_LINE];
    logic [W_DATA-1:0]    s2d_d [N_LINE];
    logic [W_PAYLOAD-1:0] pay_q [N_LINE];
    logic [W_PAYLOAD-1:0] pay_d [N_LINE];
    logic [W_CNT-1:0]     cnt_q, cnt_d;

    logic [N_LINE-1:0] rdy;
    logic [W_IDX-1:0]  sel, fre;
    logic              ins, iss;

`ifdef RS_AGE_ORDER_EN
    // age_q[i][j] = 1 means entry i is older than entry j
    logic [N_LINE-1:0] age_q [N_LINE];
    logic [N_LINE-1:0] age_d [N_LINE];
    logic [N_LINE-1:0] older;
`endif

    // Returns {hit, data}; lowest channel wins on multiple matches
    function automatic logic [W_DATA:0] wk_lookup(
        input logic [W_TAG-1:0]         t,
        input logic [N_WAKE-1:0]        v,
        input logic [N_WAKE*W_TAG-1:0]  tg,
        input logic [N_WAKE*W_DATA-1:0] dt
    );
        logic [W_DATA:0] r;
        r = '0;
        for (int k = N_WAKE - 1; k >= 0; k--) begin
            if (v[k] && tg[k*W_TAG +: W_TAG] == t)
                r = {1'b1, dt[k*W_DATA +: W_DATA]};
        end
        return r;
    endfunction

    always_comb begin
        rdy = occ_q & s1v_q & s2v_q;
        sel = '0;
`ifdef RS_AGE_ORDER_EN
        for (int i = 0; i < N_LINE; i++) begin
            older[i] = 1'b0;
            for (int j = 0; j < N_LINE; j++)
                if (rdy[j] && age_q[j][i]) older[i] = 1'b1;
        end
        for (int i = N_LINE - 1; i >= 0; i--)
            if (rdy[i] && !older[i]) sel = W_IDX'(i);
`else
        for (int i = N_LINE - 1; i >= 0; i--)
            if (rdy[i]) sel = W_IDX'(i);
`endif
        fre = '0;
        for (int i = N_LINE - 1; i >= 0; i--)
            if (!occ_q[i]) fre = W_IDX'(i);
    end

    assign rs.in_ready      = (cnt_q != W_CNT'(N_LINE));
    assign rs.out_valid     = (|rdy) & ~flash;
    assign rs.out_payload   = pay_q[sel];
    assign rs.out_src1_data = s1d_q[sel];
    assign rs.out_src2_data = s2d_q[sel];
    assign count            = cnt_q;

    assign ins = rs.in_valid & rs.in_ready & ~flash;
    assign iss = rs.out_valid & rs.out_ready;

    always_comb begin
        logic [W_DATA:0] w;
        w     = '0;
        occ_d = occ_q;
        s1v_d = s1v_q;
        s2v_d = s2v_q;
        s1t_d = s1t_q;
        s2t_d = s2t_q;
        s1d_d = s1d_q;
        s2d_d = s2d_q;
        pay_d = pay_q;
        for (int i = 0; i < N_LINE; i++) begin
            if (!s1v_q[i]) begin
                w = wk_lookup(s1t_q[i], rs.wake_valid, rs.wake_tag, rs.wake_data);
                if (w[W_DATA]) begin
                    s1v_d[i] = 1'b1;
                    s1d_d[i] = w[W_DATA-1:0];
                end
            end
            if (!s2v_q[i]) begin
                w = wk_lookup(s2t_q[i], rs.wake_valid, rs.wake_tag, rs.wake_data);
                if (w[W_DATA]) begin
                    s2v_d[i] = 1'b1;
                    s2d_d[i] = w[W_DATA-1:0];
                end
            end
        end
        if (iss) occ_d[sel] = 1'b0;
        if (ins) begin
            occ_d[fre] = 1'b1;
            pay_d[fre] = rs.in_payload;
            s1t_d[fre] = rs.in_src1_tag;
            s2t_d[fre] = rs.in_src2_tag;
            // Bypass: a broadcast seen during dispatch is captured directly
            if (rs.in_src1_valid) begin
                s1v_d[fre] = 1'b1;
                s1d_d[fre] = rs.in_src1_data;
            end else begin
                w = wk_lookup(rs.in_src1_tag, rs.wake_valid, rs.wake_tag, rs.wake_data);
                s1v_d[fre] = w[W_DATA];
                s1d_d[fre] = w[W_DATA-1:0];
            end
            if (rs.in_src2_valid) begin
                s2v_d[fre] = 1'b1;
                s2d_d[fre] = rs.in_src2_data;
            end else begin
                w = wk_lookup(rs.in_src2_tag, rs.wake_valid, rs.wake_tag, rs.wake_data);
                s2v_d[fre] = w[W_DATA];
                s2d_d[fre] = w[W_DATA-1:0];
            end
        end
        cnt_d = cnt_q + W_CNT'(ins) - W_CNT'(iss);
        if (flash) begin
            occ_d = '0;
            cnt_d = '0;
        end
    end

`ifdef RS_AGE_ORDER_EN
    always_comb begin
        age_d = age_q;
        if (ins) begin
            age_d[fre] = '0;
            for (int i = 0; i < N_LINE; i++)
                if (occ_q[i]) age_d[i][fre] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_LINE; i++) age_q[i] <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            occ_q <= '0;
            s1v_q <= '0;
            s2v_q <= '0;
            cnt_q <= '0;
        end else begin
            occ_q <= occ_d;
            s1v_q <= s1v_d;
            s2v_q <= s2v_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        s1t_q <= s1t_d;
        s2t_q <= s2t_d;
        s1d_q <= s1d_d;
        s2d_q <= s2d_d;
        pay_q <= pay_d;
    end
endmodule

// File: tb/tb_generic_rs.sv
// Directed self-checking bench for generic_rs (default parameters).
module tb_generic_rs;
    logic       clock = 1'b0;
    logic       rstn  = 1'b0;
    logic       flash = 1'b0;
    logic [4:0] count;
    int n_cmp = 0;
    int n_bad = 0;

    generic_rs_if rs ();

    generic_rs dut (
        .clock(clock),
        .rstn (rstn),
        .flash(flash),
        .rs   (rs),
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rs.in_valid      = 1'b0;
        rs.in_payload    = '0;
        rs.in_src1_valid = 1'b0;
        rs.in_src1_tag   = '0;
        rs.in_src1_data  = '0;
        rs.in_src2_valid = 1'b0;
        rs.in_src2_tag   = '0;
        rs.in_src2_data  = '0;
        rs.wake_valid    = '0;
        rs.wake_tag      = '0;
        rs.wake_data     = '0;
        rs.out_ready     = 1'b0;
        flash            = 1'b0;
    endtask

    task automatic drive_in(input logic [47:0] p,
                            input logic v1, input logic [5:0] t1, input logic [31:0] d1,
                            input logic v2, input logic [5:0] t2, input logic [31:0] d2);
        rs.in_valid      = 1'b1;
        rs.in_payload    = p;
        rs.in_src1_valid = v1;
        rs.in_src1_tag   = t1;
        rs.in_src1_data  = d1;
        rs.in_src2_valid = v2;
        rs.in_src2_tag   = t2;
        rs.in_src2_data  = d2;
    endtask

    task automatic wake(input logic [1:0] v, input logic [5:0] t0, input logic [31:0] d0,
                        input logic [5:0] t1, input logic [31:0] d1);
        rs.wake_valid = v;
        rs.wake_tag   = {t1, t0};
        rs.wake_data  = {d1, d0};
    endtask

    task automatic test_reset();
        idle();
        #12;
        n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", count); end
        n_cmp++; if (rs.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", rs.out_valid); end
        n_cmp++; if (rs.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", rs.in_ready); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive_in(48'h100, 1'b1, 6'd0, 32'h5, 1'b1, 6'd0, 32'h7);
        #1;
        n_cmp++; if (rs.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency got=%b want=0", rs.out_valid); end
        tick();
        idle();
        #1;
        n_cmp++; if (rs.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%b want=1", rs.out_valid); end
        n_cmp++; if (rs.out_src1_data !== 32'h5) begin n_bad++; $display("FAIL basic_src1 got=%h want=5", rs.out_src1_data); end
        n_cmp++; if (rs.out_src2_data !== 32'h7) begin n_bad++; $display("FAIL basic_src2 got=%h want=7", rs.out_src2_data); end
        n_cmp++; if (rs.out_payload !== 48'h100) begin n_bad++; $display("FAIL basic_payload got=%h want=100", rs.out_payload); end
        n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL basic_count1 got=%0d want=1", count); end
        rs.out_ready = 1'b1;
        tick();
        rs.out_ready = 1'b0;
        #1;
        n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL basic_count0 got=%0d want=0", count); end
        n_cmp++; if (rs.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_empty got=%b want=0", rs.out_valid); end
    endtask

    task automatic test_bypass();
        drive_in(48'h200, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'h3);
        wake(2'b01, 6'd12, 32'hAA, 6'd0, 32'h0);
        tick();
        idle();
        #1;
        n_cmp++; if (rs.out_valid !== 1'b1) begin n_bad++; $display("FAIL bypass_valid got=%b want=1", rs.out_valid); end
        n_cmp++; if (rs.out_src1_data !== 32'hAA) begin n_bad++; $display("FAIL bypass_src1 got=%h want=aa", rs.out_src1_data); end
        rs.out_ready = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_wake_prio();
        drive_in(48'h300, 1'b0, 6'd3, 32'h0, 1'b1, 6'd0, 32'h1);
        tick();
        idle();
        #1;
        n_cmp++; if (rs.out_valid !== 1'b0) begin n_bad++; $display("FAIL prio_wait got=%b want=0", rs.out_valid); end
        wake(2'b11, 6'd3, 32'h11, 6'd3, 32'h22);
        #1;
        n_cmp++; if (rs.out_valid !== 1'b0) begin n_bad++; $display("FAIL prio_same_cycle got=%b want=0", rs.out_valid); end
        tick();
        idle();
        #1;
        n_cmp++; if (rs.out_src1_data !== 32'h11) begin n_bad++; $display("FAIL prio_src1 got=%h want=11", rs.out_src1_data); end
        rs.out_ready = 1'b1;
        tick();
        idle();
        drive_in(48'h301, 1'b1, 6'd0, 32'h2, 1'b0, 6'd9, 32'h0);
        tick();
        idle();
        wake(2'b10, 6'd9, 32'h44, 6'd9, 32'h33);
        tick();
        idle();
        #1;
        n_cmp++; if (rs.out_src2_data !== 32'h33) begin n_bad++; $display("FAIL ch1_src2 got=%h want=33", rs.out_src2_data); end
        rs.out_ready = 1'b1;
        tick();
        idle();
        #1;
        n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL prio_drain got=%0d want=0", count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive_in(48'(i), 1'b0, 6'(32 + i), 32'h0, 1'b1, 6'd0, 32'h9);
            tick();
        end
        idle();
        #1;
        n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL full_count got=%0d want=16", count); end
        n_cmp++; if (rs.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got=%b want=0", rs.in_ready); end
        drive_in(48'hBAD, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h1);
        tick();
        idle();
        #1;
        n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL full_17th got=%0d want=16", count); end
        wake(2'b01, 6'd37, 32'h55, 6'd0, 32'h0);
        tick();
        idle();
        #1;
        n_cmp++; if (rs.out_payload !== 48'd5) begin n_bad++; $display("FAIL full_pick got=%h want=5", rs.out_payload); end
        n_cmp++; if (rs.out_src1_data !== 32'h55) begin n_bad++; $display("FAIL full_src1 got=%h want=55", rs.out_src1_data); end
        rs.out_ready = 1'b1;
        #1;
        n_cmp++; if (rs.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_same_cycle got=%b want=0", rs.in_ready); end
        tick();
        idle();
        #1;
        n_cmp++; if (rs.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_freed got=%b want=1", rs.in_ready); end
        n_cmp++; if (count !== 5'd15) begin n_bad++; $display("FAIL full_count15 got=%0d want=15", count); end
        flash = 1'b1;
        tick();
        idle();
        #1;
        n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL full_flush got=%0d want=0", count); end
    endtask

    task automatic test_back_to_back();
        drive_in(48'h400, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
        tick();
        drive_in(48'h401, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 32'h4);
        rs.out_ready = 1'b1;
        tick();
        idle();
        #1;
        n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL b2b_count got=%0d want=1", count); end
        n_cmp++; if (rs.out_payload !== 48'h401) begin n_bad++; $display("FAIL b2b_payload got=%h want=401", rs.out_payload); end
        rs.out_ready = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_order();
        logic [47:0] first;
        logic [47:0] second;
`ifdef RS_AGE_ORDER_EN
        first  = 48'hB;
        second = 48'hC;
`else
        first  = 48'hC;
        second = 48'hB;
`endif
        drive_in(48'hA, 1'b0, 6'd50, 32'h0, 1'b1, 6'd0, 32'h0);
        tick();
        drive_in(48'hB, 1'b0, 6'd51, 32'h0, 1'b1, 6'd0, 32'h0);
        tick();
        idle();
        wake(2'b01, 6'd50, 32'h1, 6'd0, 32'h0);
        tick();
        idle();
        rs.out_ready = 1'b1;
        tick();
        idle();
        drive_in(48'hC, 1'b0, 6'd52, 32'h0, 1'b1, 6'd0, 32'h0);
        tick();
        idle();
        wake(2'b11, 6'd51, 32'hB0, 6'd52, 32'hC0);
        tick();
        idle();
        #1;
        n_cmp++; if (rs.out_payload !== first) begin n_bad++; $display("FAIL order_first got=%h want=%h", rs.out_payload, first); end
        rs.out_ready = 1'b1;
        tick();
        idle();
        #1;
        n_cmp++; if (rs.out_payload !== second) begin n_bad++; $display("FAIL order_second got=%h want=%h", rs.out_payload, second); end
        rs.out_ready = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_flash();
        for (int i = 0; i < 5; i++) begin
            drive_in(48'(16 + i), 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h1);
            tick();
        end
        idle();
        #1;
        n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL flash_pre got=%0d want=5", count); end
        flash = 1'b1;
        rs.out_ready = 1'b1;
        drive_in(48'h99, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h1);
        #1;
        n_cmp++; if (rs.out_valid !== 1'b0) begin n_bad++; $display("FAIL flash_out_valid got=%b want=0", rs.out_valid); end
        tick();
        idle();
        #1;
        n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL flash_count got=%0d want=0", count); end
        n_cmp++; if (rs.out_valid !== 1'b0) begin n_bad++; $display("FAIL flash_after got=%b want=0", rs.out_valid); end
        drive_in(48'h77, 1'b1, 6'd0, 32'h6, 1'b1, 6'd0, 32'h8);
        tick();
        idle();
        #1;
        n_cmp++; if (rs.out_payload !== 48'h77) begin n_bad++; $display("FAIL flash_next got=%h want=77", rs.out_payload); end
        n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL flash_next_cnt got=%0d want=1", count); end
    endtask

    task automatic test_async_reset();
        drive_in(48'h55, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h1);
        tick();
        idle();
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL areset_count got=%0d want=0", count); end
        n_cmp++; if (rs.out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid got=%b want=0", rs.out_valid); end
        n_cmp++; if (rs.in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_ready got=%b want=1", rs.in_ready); end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_wake_prio();
        test_full();
        test_back_to_back();
        test_order();
        test_flash();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
